issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- Decode-to-execute issue controller, placed between Decoder outputs and the execute stage.
- Keeps a per-register busy scoreboard for pending writebacks.
- Stalls decode on RAW/WAW hazards or when the in-flight limit is reached.
- Holds a single valid/ready issue register that feeds the ALU.

Parameters:
- ADDRESS_SIZE, 32, data/immediate width.
- REG_ADDRESS_SIZE, 5, register address width; NUM_REGS = 2**REG_ADDRESS_SIZE.
- MAX_INFLIGHT, 4, maximum issued-but-not-written-back register writes (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_addr_r1  in  REG_ADDRESS_SIZE  source 1.
- in_addr_r2  in  REG_ADDRESS_SIZE  source 2.
- in_addr_rd  in  REG_ADDRESS_SIZE  destination.
- in_register_write  in  1  instruction writes rd.
- in_use_immediate  in  1  r2 unused when 1.
- in_immediate  in  ADDRESS_SIZE  sign-extended immediate.
- in_function_block  in  2  execute unit select.
- in_operation  in  3  funct3.
- out_valid  out  1  issue register holds an instruction.
- out_ready  in  1  execute stage consumes when out_valid && out_ready.
- out_addr_r1, out_addr_r2, out_addr_rd, out_register_write, out_use_immediate, out_immediate, out_function_block, out_operation  out  (widths as inputs)  registered copies.
- wb_valid  in  1  writeback completing this cycle.
- wb_addr  in  REG_ADDRESS_SIZE  register being written back.
- inflight  out  4  current in-flight write count.
- wb_error  out  1  sticky: writeback to a register not marked busy.

Behaviour:
- Reset (async, immediate): busy[] = 0; inflight = 0; out_valid = 0; all out_* fields = 0; wb_error = 0.
- Effective busy: busy_eff[i] = busy[i] && !(wb_valid && wb_addr == i). A same-cycle writeback is bypassed because the regfile is write-before-read. busy_eff[0] = 0 always.
- hazard asserts if any of the following holds:
  - busy_eff[in_addr_r1];
  - !in_use_immediate && busy_eff[in_addr_r2];
  - in_register_write && busy_eff[in_addr_rd] (WAW);
  - inflight == MAX_INFLIGHT && !(wb_valid && busy[wb_addr]) (a valid writeback frees its slot in the same cycle).
- in_ready = !hazard && (!out_valid || out_ready). Combinational; does not depend on in_valid.
- Accept (in_valid && in_ready): load all in_* into the out_* registers; out_valid = 1 next cycle.
- Else if out_valid && out_ready: out_valid = 0, fields hold.
- Issue latency: 1 cycle from accept to out_valid. Back-to-back issue at full rate when no hazard and out_ready = 1.
- Set condition: accept && in_register_write && in_addr_rd != 0 sets busy[rd].
- Clear condition: wb_valid && busy[wb_addr] clears busy[wb_addr].
- Same-cycle set and clear on the same register: set wins.
- inflight: +1 on set, -1 on valid clear, unchanged when both occur. Never wraps; the hazard rule guarantees inflight ≤ MAX_INFLIGHT.
- wb_valid with wb_addr == 0 or with busy[wb_addr] == 0: no state change except wb_error <= 1. wb_error holds until reset.
- A stall on out_ready does not block writeback clears. The scoreboard keeps updating while the issue register is held.
- Reset mid-operation discards the issue register and all busy bits. The surrounding pipeline is flushed by the same reset.

Optional Feature:
- Macro ISSUE_SCOREBOARD_STATS_EN.
- Defined: adds output stall_cycles [31:0]. It increments every cycle with in_valid && hazard, saturates at 32'hFFFFFFFF, and resets to 0.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Independent stream: addi x1,x0,5 then addi x2,x0,7 with out_ready=1, no wb → both accepted on consecutive cycles; inflight = 2; busy[1] = busy[2] = 1.
- RAW stall: issue rd=x3, then in_addr_r1=x3 → in_ready=0 until wb_valid with wb_addr=3. Accept occurs in that same wb cycle through the bypass.
- x0 handling: rd=x0 with register_write=1 → busy unchanged, inflight stays 0; a following r1=x0 is never stalled.
- Capacity: issue 4 writes to x1..x4 with no wb → 5th in_valid sees in_ready=0. Asserting wb_valid, wb_addr=1 in that cycle → 5th accepted; inflight stays 4.
- Backpressure: out_ready=0 with out_valid=1 → in_ready=0 and out_* stable. A wb to x2 during the hold still clears busy[2]; inflight decrements.
- Error/reset: wb_valid with wb_addr=9 while not busy → wb_error=1 and stays 1. Async reset mid-stall → out_valid, inflight, busy[], wb_error all 0 immediately.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Decode-side, issue-side and writeback signals of the issue scoreboard.
// master = decoder/execute environment, slave = issue_scoreboard.
interface issue_scoreboard_if #(
    parameter int ADDRESS_SIZE     = 32,
    parameter int REG_ADDRESS_SIZE = 5
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready may depend on state and on the other inputs but never on valid.
    logic                        in_valid;
    logic                        in_ready;
    logic [REG_ADDRESS_SIZE-1:0] in_addr_r1;
    logic [REG_ADDRESS_SIZE-1:0] in_addr_r2;
    logic [REG_ADDRESS_SIZE-1:0] in_addr_rd;
    logic                        in_register_write;
    logic                        in_use_immediate;
    logic [ADDRESS_SIZE-1:0]     in_immediate;
    logic [1:0]                  in_function_block;
    logic [2:0]                  in_operation;

    logic                        out_valid;
    logic                        out_ready;
    logic [REG_ADDRESS_SIZE-1:0] out_addr_r1;
    logic [REG_ADDRESS_SIZE-1:0] out_addr_r2;
    logic [REG_ADDRESS_SIZE-1:0] out_addr_rd;
    logic                        out_register_write;
    logic                        out_use_immediate;
    logic [ADDRESS_SIZE-1:0]     out_immediate;
    logic [1:0]                  out_function_block;
    logic [2:0]                  out_operation;

    logic                        wb_valid;
    logic [REG_ADDRESS_SIZE-1:0] wb_addr;

    modport master (
        output in_valid, in_addr_r1, in_addr_r2, in_addr_rd, in_register_write,
               in_use_immediate, in_immediate, in_function_block, in_operation,
        input  in_ready,
        input  out_valid, out_addr_r1, out_addr_r2, out_addr_rd, out_register_write,
               out_use_immediate, out_immediate, out_function_block, out_operation,
        output out_ready,
        output wb_valid, wb_addr
    );

    modport slave (
        input  in_valid, in_addr_r1, in_addr_r2, in_addr_rd, in_register_write,
               in_use_immediate, in_immediate, in_function_block, in_operation,
        output in_ready,
        output out_valid, out_addr_r1, out_addr_r2, out_addr_rd, out_register_write,
               out_use_immediate, out_immediate, out_function_block, out_operation,
        input  out_ready,
        input  wb_valid, wb_addr
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue stage: busy-register scoreboard, hazard stall and one issue register.
// Optional macro ISSUE_SCOREBOARD_STATS_EN adds the stall_cycles counter output.
module issue_scoreboard #(
    parameter int ADDRESS_SIZE     = 32,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int MAX_INFLIGHT     = 4,
    localparam int NUM_REGS        = 2 ** REG_ADDRESS_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    issue_scoreboard_if.slave   bus,
    output logic [3:0]          inflight,
    output logic                wb_error,
    output logic [NUM_REGS-1:0] busy_state
`ifdef ISSUE_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] wb_onehot;
    logic                wb_hit;
    logic                cap_full;
    logic                hazard;
    logic                accept;
    logic                set_en;

    always_comb begin
        wb_onehot = '0;
        if (bus.wb_valid) wb_onehot[bus.wb_addr] = 1'b1;
        // The regfile is write-before-read, so a same-cycle writeback is already visible.
        busy_eff    = busy & ~wb_onehot;
        busy_eff[0] = 1'b0;
        wb_hit      = bus.wb_valid && busy[bus.wb_addr];
        cap_full    = (inflight == 4'(MAX_INFLIGHT)) && !wb_hit;
        hazard      = busy_eff[bus.in_addr_r1]
                   || (!bus.in_use_immediate && busy_eff[bus.in_addr_r2])
                   || (bus.in_register_write && busy_eff[bus.in_addr_rd])
                   || cap_full;
        bus.in_ready = !hazard && (!bus.out_valid || bus.out_ready);
        accept       = bus.in_valid && bus.in_ready;
        set_en       = accept && bus.in_register_write && (bus.in_addr_rd != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid          <= 1'b0;
            bus.out_addr_r1        <= '0;
            bus.out_addr_r2        <= '0;
            bus.out_addr_rd        <= '0;
            bus.out_register_write <= 1'b0;
            bus.out_use_immediate  <= 1'b0;
            bus.out_immediate      <= '0;
            bus.out_function_block <= '0;
            bus.out_operation      <= '0;
        end else if (accept) begin
            bus.out_valid          <= 1'b1;
            bus.out_addr_r1        <= bus.in_addr_r1;
            bus.out_addr_r2        <= bus.in_addr_r2;
            bus.out_addr_rd        <= bus.in_addr_rd;
            bus.out_register_write <= bus.in_register_write;
            bus.out_use_immediate  <= bus.in_use_immediate;
            bus.out_immediate      <= bus.in_immediate;
            bus.out_function_block <= bus.in_function_block;
            bus.out_operation      <= bus.in_operation;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Clear is written before set so a same-register set/clear leaves the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            inflight <= '0;
            wb_error <= 1'b0;
        end else begin
            if (wb_hit) busy[bus.wb_addr] <= 1'b0;
            if (set_en) busy[bus.in_addr_rd] <= 1'b1;
            if (set_en && !wb_hit) inflight <= inflight + 4'd1;
            else if (!set_en && wb_hit) inflight <= inflight - 4'd1;
            if (bus.wb_valid && !busy[bus.wb_addr]) wb_error <= 1'b1;
        end
    end

    assign busy_state = busy;

`ifdef ISSUE_SCOREBOARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cycles <= '0;
        else if (bus.in_valid && hazard && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule
